// File: rtl/jam_pkg.sv
// Shared types and default sizes for the cost-table lookup arbiter.
package jam_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    localparam int AW_DEF    = 3;
    localparam int CW_DEF    = 7;
    localparam int BURST_DEF = 8;

endpackage

// File: rtl/jam_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module jam_rr_pick
    import jam_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int cand;

    // Scan from the farthest candidate down to the nearest so the nearest one overwrites.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = 0;
        for (int off = NREQ; off >= 1; off--) begin
            cand = (int'(ptr) + off) % NREQ;
            if (req[cand]) begin
                onehot       = '0;
                onehot[cand] = 1'b1;
                idx          = IW'(cand);
                any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jam_cost_arbiter.sv
// Burst arbiter sharing one cost-table port among NREQ permutation engines.
// Define JAM_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module jam_cost_arbiter
    import jam_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int BURST = BURST_DEF,
    parameter int AW    = AW_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_w,
    input  logic [NREQ*AW-1:0] req_j,
    output logic [NREQ-1:0]    gnt,
    output logic [AW-1:0]      W,
    output logic [AW-1:0]      J,
    input  logic [CW-1:0]      Cost,
    output logic [CW-1:0]      rsp_cost,
    output logic [NREQ-1:0]    rsp_vld,
    output logic               rsp_last,
    output logic               busy
);

    localparam int IW = $clog2(NREQ);
    localparam int BW = $clog2(BURST);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

    state_t          state, nstate;
    logic [BW-1:0]   beat;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   ptr;
    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [AW-1:0]   sel_w, sel_j;
    logic [NREQ-1:0] iss_oh;
    logic            iss_last;

`ifdef JAM_ARB_FIXED_PRIO_EN
    // Scanning after the top index makes index 0 always the nearest candidate.
    assign ptr = IW'(NREQ - 1);
`else
    logic [IW-1:0] rr_ptr;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                       rr_ptr <= IW'(NREQ - 1);
        else if (state == IDLE && pick_any) rr_ptr <= pick_idx;
    end

    assign ptr = rr_ptr;
`endif

    jam_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        sel_w = '0;
        sel_j = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == IW'(i)) begin
                sel_w = req_w[i*AW +: AW];
                sel_j = req_j[i*AW +: AW];
            end
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (pick_any) nstate = ISSUE;
            ISSUE:   if (beat == LAST_BEAT) nstate = DRAIN;
            DRAIN:   nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            gnt   <= '0;
            beat  <= '0;
            owner <= '0;
            W     <= '0;
            J     <= '0;
        end else begin
            state <= nstate;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt   <= pick_oh;
                        owner <= pick_idx;
                        beat  <= '0;
                    end
                end
                ISSUE: begin
                    W <= sel_w;
                    J <= sel_j;
                    // beat saturates at the last index; gnt drops as ISSUE ends
                    if (beat == LAST_BEAT) gnt  <= '0;
                    else                   beat <= beat + BW'(1);
                end
                DRAIN: begin
                    W <= '0;
                    J <= '0;
                end
                default: ;
            endcase
        end
    end

    // Stage 1 lines up with W/J; stage 2 captures Cost for that address.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            iss_oh   <= '0;
            iss_last <= 1'b0;
            rsp_vld  <= '0;
            rsp_last <= 1'b0;
            rsp_cost <= '0;
        end else begin
            iss_oh   <= (state == ISSUE) ? gnt : '0;
            iss_last <= (state == ISSUE) && (beat == LAST_BEAT);
            rsp_vld  <= iss_oh;
            rsp_last <= iss_last;
            if (|iss_oh) rsp_cost <= Cost;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_jam_cost_arbiter.sv
// Randomized scoreboard bench for jam_cost_arbiter with a cycle-level arbitration model.
module tb_jam_cost_arbiter;

    localparam int NREQ  = 4;
    localparam int BURST = 8;
    localparam int AW    = 3;
    localparam int CW    = 7;

    logic               CLK = 1'b0;
    logic               RST_N = 1'b1;
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_w, req_j;
    logic [NREQ-1:0]    gnt;
    logic [AW-1:0]      W, J;
    logic [CW-1:0]      Cost, rsp_cost;
    logic [NREQ-1:0]    rsp_vld;
    logic               rsp_last, busy;

    logic [CW-1:0] tbl [1<<AW][1<<AW];
    assign Cost = tbl[W][J];

    always #5 CLK = ~CLK;

    jam_cost_arbiter #(.NREQ(NREQ), .BURST(BURST), .AW(AW), .CW(CW)) dut (
        .CLK(CLK), .RST_N(RST_N), .req(req), .req_w(req_w), .req_j(req_j),
        .gnt(gnt), .W(W), .J(J), .Cost(Cost), .rsp_cost(rsp_cost),
        .rsp_vld(rsp_vld), .rsp_last(rsp_last), .busy(busy)
    );

    typedef struct {
        int            eng;
        logic [CW-1:0] cost;
        logic          last;
    } exp_t;

    exp_t sbq[$];
    int   glog[$];
    int   cnt[NREQ];
    int   perm[NREQ][BURST];
    int   total = 0, bad = 0;
    int   cyc = 0, last_g = -100, last_w = NREQ - 1;
    int   vld1 = 0;
    logic [NREQ-1:0] prev_gnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait expired (cycle %0d)", name, cyc);
    endtask

    task automatic new_perm(input int i);
        for (int b = 0; b < BURST; b++) perm[i][b] = b;
        for (int b = BURST - 1; b > 0; b--) begin
            int r = $urandom_range(b, 0);
            int t = perm[i][b];
            perm[i][b] = perm[i][r];
            perm[i][r] = t;
        end
    endtask

    // Winner by the arbitration rule, given the previous winner.
    function automatic int pick(input logic [NREQ-1:0] r, input int lastw);
`ifdef JAM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= NREQ; k++) if (r[(lastw + k) % NREQ]) return (lastw + k) % NREQ;
`endif
        return -1;
    endfunction

    // Engines: present (row=beat, col=perm[beat]); each granted cycle consumes one address.
    task automatic step();
        @(negedge CLK);
        for (int i = 0; i < NREQ; i++) begin
            req_w[i*AW +: AW] = AW'(cnt[i]);
            req_j[i*AW +: AW] = AW'(perm[i][cnt[i]]);
            if (RST_N && gnt[i]) begin
                sbq.push_back('{eng: i, cost: tbl[cnt[i]][perm[i][cnt[i]]], last: (cnt[i] == BURST - 1)});
                cnt[i]++;
                if (cnt[i] == BURST) begin
                    cnt[i] = 0;
                    new_perm(i);
                end
            end
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_cnt(input int eng, input int val, input string name);
        for (int k = 0; k < 40; k++) begin
            if (cnt[eng] == val) return;
            step();
        end
        timeout(name);
    endtask

    task automatic wait_grants(input int n, input string name);
        for (int k = 0; k < 80; k++) begin
            if (glog.size() >= n) return;
            step();
        end
        timeout(name);
    endtask

    // Monitor: model says when a grant may start and how long each phase of a burst lasts.
    initial begin
        int d, w, exp_g, exp_v;
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            if (gnt != 0 && prev_gnt == 0) begin
                w = -1;
                for (int i = 0; i < NREQ; i++) if (gnt[i]) w = i;
                glog.push_back(w);
            end
            prev_gnt = gnt;
            if (rsp_vld[1]) vld1++;
            if (!RST_N) begin
                chk("rst_gnt", gnt, 0);
                chk("rst_vld", rsp_vld, 0);
                chk("rst_busy", busy, 0);
                chk("rst_last", rsp_last, 0);
                chk("rst_cost", rsp_cost, 0);
                chk("rst_wj", {W, J}, 0);
                last_g = -100;
                last_w = NREQ - 1;
            end else begin
                if (cyc - last_g >= BURST + 2 && req != 0) begin
                    last_w = pick(req, last_w);
                    last_g = cyc;
                end
                d     = cyc - last_g;
                exp_g = (d < BURST) ? (1 << last_w) : 0;
                exp_v = (d >= 2 && d <= BURST + 1) ? (1 << last_w) : 0;
                chk("gnt", gnt, exp_g);
                chk("busy", busy, d <= BURST);
                chk("rsp_vld", rsp_vld, exp_v);
                chk("rsp_last", rsp_last, d == BURST + 1);
                if (d == 0 || d > BURST) chk("wj_idle", {W, J}, 0);
                if (rsp_vld != 0) begin
                    if (sbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_underflow: got rsp_vld %0h with nothing expected", rsp_vld);
                    end else begin
                        e = sbq.pop_front();
                        chk("rsp_owner", rsp_vld, 1 << e.eng);
                        chk("rsp_cost", rsp_cost, e.cost);
                        chk("rsp_last_beat", rsp_last, e.last);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        req   = '0;
        req_w = '0;
        req_j = '0;
        for (int a = 0; a < (1 << AW); a++)
            for (int b = 0; b < (1 << AW); b++) tbl[a][b] = CW'($urandom);
        for (int i = 0; i < NREQ; i++) begin
            cnt[i] = 0;
            new_perm(i);
        end
        #1 RST_N = 1'b0;
        steps(3);
        RST_N = 1'b1;

        // All engines requesting: rotation starts at engine 0, grants 10 cycles apart.
        req = 4'b1111;
        wait_grants(5, "wait_rr5");
        req = '0;
        steps(12);
`ifdef JAM_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 5; k++) chk("order_fixed", glog[k], 0);
`else
        chk("order_0", glog[0], 0);
        chk("order_1", glog[1], 1);
        chk("order_2", glog[2], 2);
        chk("order_3", glog[3], 3);
        chk("order_4", glog[4], 0);
`endif

        // Single engine walking (0,3),(1,5),...
        for (int b = 0; b < BURST; b++) perm[0][b] = (3 + 2 * b) % BURST;
        req = 4'b0001;
        step();
        req = '0;
        steps(14);

        // Engine 2 served, then 0110: engine 1 wins.
        req = 4'b0100;
        step();
        req = '0;
        steps(12);
        n0 = glog.size();
        req = 4'b0110;
        wait_grants(n0 + 1, "wait_wrap");
        req = '0;
        steps(12);
        if (glog.size() > n0) chk("wrap_winner", glog[n0], 1);

        // Engine 1 drops its request at beat 3; the burst still completes.
        vld1 = 0;
        req  = 4'b0010;
        step();
        wait_cnt(1, 3, "wait_beat3");
        req = '0;
        steps(14);
        chk("drop_beats", vld1, BURST);

        // Reset at beat 5: partial burst vanishes, engine 0 wins first afterwards.
        req = 4'b0001;
        step();
        wait_cnt(0, 5, "wait_beat5");
        RST_N = 1'b0;
        sbq.delete();
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        req = 4'b1111;
        steps(2);
        n0 = glog.size();
        RST_N = 1'b1;
        wait_grants(n0 + 1, "wait_post_rst");
        if (glog.size() > n0) chk("post_rst_winner", glog[n0], 0);

        // Random request patterns.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(5, 0) == 0) req = NREQ'($urandom);
            step();
        end
        req = '0;
        steps(20);
        chk("sb_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
